// File: rtl/fp_mult_arbiter.sv
// Round-robin front end that shares one pipelined FP multiplier between NB_CORES requesters.
// A credit counter bounds in-flight operations; returning results are registered and routed by tag.
module fp_mult_arbiter #(
    parameter int NB_CORES        = 4,
    parameter int FP_WIDTH        = 32,
    parameter int RND_WIDTH       = 3,
    parameter int STAT_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 4,
    localparam int TAG_WIDTH      = $clog2(NB_CORES)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NB_CORES-1:0]           req_i,
    input  logic [NB_CORES*FP_WIDTH-1:0]  opa_i,
    input  logic [NB_CORES*FP_WIDTH-1:0]  opb_i,
    input  logic [NB_CORES*RND_WIDTH-1:0] rnd_i,
    output logic [NB_CORES-1:0]           gnt_o,
    output logic [NB_CORES-1:0]           rvalid_o,
    output logic [FP_WIDTH-1:0]           res_o,
    output logic [STAT_WIDTH-1:0]         status_o,
    output logic                          err_o,
    output logic                          unit_en_o,
    output logic [FP_WIDTH-1:0]           unit_opa_o,
    output logic [FP_WIDTH-1:0]           unit_opb_o,
    output logic [RND_WIDTH-1:0]          unit_rnd_o,
    output logic [TAG_WIDTH-1:0]          unit_tag_o,
    input  logic                          unit_ready_i,
    input  logic                          unit_valid_i,
    input  logic [TAG_WIDTH-1:0]          unit_tag_i,
    input  logic [FP_WIDTH-1:0]           unit_res_i,
    input  logic [STAT_WIDTH-1:0]         unit_status_i,
    output logic                          unit_ack_o
);

    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    logic [TAG_WIDTH-1:0] rr_ptr;
    logic [TAG_WIDTH-1:0] ptr_nxt;
    logic [CNT_WIDTH-1:0] count;
    logic                 issue_ok;
    logic                 issue;
    logic [TAG_WIDTH-1:0] gnt_idx;
    logic                 tag_in_range;
    logic                 ret_dec;

    logic [FP_WIDTH-1:0]  opa_arr [NB_CORES];
    logic [FP_WIDTH-1:0]  opb_arr [NB_CORES];
    logic [RND_WIDTH-1:0] rnd_arr [NB_CORES];

    for (genvar k = 0; k < NB_CORES; k++) begin : g_unpack
        assign opa_arr[k] = opa_i[k*FP_WIDTH +: FP_WIDTH];
        assign opb_arr[k] = opb_i[k*FP_WIDTH +: FP_WIDTH];
        assign rnd_arr[k] = rnd_i[k*RND_WIDTH +: RND_WIDTH];
    end

    // Gating with rst_ni keeps the multiplier from seeing issues while it is itself in reset.
    assign issue_ok = rst_ni && unit_ready_i && (count < CNT_WIDTH'(MAX_OUTSTANDING));

    always_comb begin
        int idx;
        issue   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (issue_ok) begin
            for (int i = 0; i < NB_CORES; i++) begin
                idx = (int'(rr_ptr) + i) % NB_CORES;
                if (!issue && req_i[TAG_WIDTH'(idx)]) begin
                    issue   = 1'b1;
                    gnt_idx = TAG_WIDTH'(idx);
                end
            end
        end
    end

    assign ptr_nxt    = (gnt_idx == TAG_WIDTH'(NB_CORES - 1)) ? '0 : gnt_idx + 1'b1;
    assign gnt_o      = issue ? (NB_CORES'(1) << gnt_idx) : '0;
    assign unit_en_o  = issue;
    assign unit_opa_o = issue ? opa_arr[gnt_idx] : '0;
    assign unit_opb_o = issue ? opb_arr[gnt_idx] : '0;
    assign unit_rnd_o = issue ? rnd_arr[gnt_idx] : '0;
    assign unit_tag_o = issue ? gnt_idx : '0;
    assign unit_ack_o = unit_valid_i;

    assign tag_in_range = {1'b0, unit_tag_i} < (TAG_WIDTH + 1)'(NB_CORES);
    // A return with no credit outstanding is a protocol error and must not underflow the counter.
    assign ret_dec      = unit_valid_i && (count != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            count    <= '0;
            rvalid_o <= '0;
            res_o    <= '0;
            status_o <= '0;
            err_o    <= 1'b0;
        end else begin
            if (issue) begin
                rr_ptr <= ptr_nxt;
            end
            count    <= count + CNT_WIDTH'(issue) - CNT_WIDTH'(ret_dec);
            rvalid_o <= '0;
            if (unit_valid_i && tag_in_range) begin
                rvalid_o <= NB_CORES'(1) << unit_tag_i;
                res_o    <= unit_res_i;
                status_o <= unit_status_i;
            end
            if (unit_valid_i && ((count == '0) || !tag_in_range)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: a queue-based multiplier stub plus a cycle model of grants,
// credits and result routing, driven by directed scenarios followed by a random phase.
module tb_fp_mult_arbiter;

    localparam int NC   = 4;
    localparam int FW   = 32;
    localparam int RW   = 3;
    localparam int SW   = 8;
    localparam int MAXO = 2;
    localparam int TW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NC-1:0]     req;
    logic [FW-1:0]     opa [NC];
    logic [FW-1:0]     opb [NC];
    logic [RW-1:0]     rnd [NC];
    logic [NC*FW-1:0]  opa_bus, opb_bus;
    logic [NC*RW-1:0]  rnd_bus;
    logic              ready;

    logic [NC-1:0] gnt, rvalid;
    logic [FW-1:0] res, unit_opa, unit_opb, unit_res;
    logic [SW-1:0] status, unit_status;
    logic          err, unit_en, unit_valid, unit_ack;
    logic [RW-1:0] unit_rnd;
    logic [TW-1:0] unit_tag, unit_tag_in;

    logic          st_valid, inj_valid;
    logic [TW-1:0] st_tag, inj_tag;
    logic [FW-1:0] st_res, inj_res;
    logic [SW-1:0] st_stat, inj_stat;

    assign unit_valid  = st_valid | inj_valid;
    assign unit_tag_in = inj_valid ? inj_tag  : st_tag;
    assign unit_res    = inj_valid ? inj_res  : st_res;
    assign unit_status = inj_valid ? inj_stat : st_stat;

    always_comb begin
        opa_bus = '0;
        opb_bus = '0;
        rnd_bus = '0;
        for (int k = 0; k < NC; k++) begin
            opa_bus[k*FW +: FW] = opa[k];
            opb_bus[k*FW +: FW] = opb[k];
            rnd_bus[k*RW +: RW] = rnd[k];
        end
    end

    fp_mult_arbiter #(
        .NB_CORES(NC), .FP_WIDTH(FW), .RND_WIDTH(RW), .STAT_WIDTH(SW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .opa_i(opa_bus), .opb_i(opb_bus),
        .rnd_i(rnd_bus), .gnt_o(gnt), .rvalid_o(rvalid), .res_o(res), .status_o(status),
        .err_o(err), .unit_en_o(unit_en), .unit_opa_o(unit_opa), .unit_opb_o(unit_opb),
        .unit_rnd_o(unit_rnd), .unit_tag_o(unit_tag), .unit_ready_i(ready),
        .unit_valid_i(unit_valid), .unit_tag_i(unit_tag_in), .unit_res_i(unit_res),
        .unit_status_i(unit_status), .unit_ack_o(unit_ack)
    );

    // Truncating single-precision multiply for normal operands; enough for a stand-in unit.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [7:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = a[30:23] + b[30:23] - 8'd127;
        if (m[47]) return {s, e + 8'd1, m[46:24]};
        return {s, e, m[45:23]};
    endfunction

    typedef struct {
        int            due;
        logic [TW-1:0] tag;
        logic [FW-1:0] res;
        logic [SW-1:0] st;
    } op_t;

    op_t q[$];
    int  lat = 2;
    int  cyc = 0;

    // Multiplier stub: fixed latency, in-order, discards everything on reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            st_valid <= 1'b0;
        end else begin
            if (unit_en)
                q.push_back('{cyc + lat, unit_tag, fmul(unit_opa, unit_opb),
                              {unit_tag, 3'b101, unit_rnd}});
            if (q.size() > 0 && q[0].due <= cyc + 1) begin
                st_valid <= 1'b1;
                st_tag   <= q[0].tag;
                st_res   <= q[0].res;
                st_stat  <= q[0].st;
                void'(q.pop_front());
            end else begin
                st_valid <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    int            m_ptr, m_infl;
    logic [NC-1:0] m_rv;
    logic [FW-1:0] m_res;
    logic [SW-1:0] m_st;
    logic          m_err;
    bit            known = 0;

    logic [NC-1:0] obs_gnt, obs_rv, last_gnt = '0;
    logic          obs_en, obs_err;
    logic [TW-1:0] obs_tag;
    logic [FW-1:0] obs_res;
    logic [NC-1:0] hist [8];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        int            k;
        logic [NC-1:0] eg;
        bit            ret;
        logic [TW-1:0] rtag;
        logic [FW-1:0] rres;
        logic [SW-1:0] rstat;
        @(negedge clk);
        k = -1;
        if (rst_n && ready && m_infl < MAXO) begin
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (m_ptr + i) % NC;
                if (k < 0 && req[c]) k = c;
            end
        end
        eg = (k >= 0) ? (4'b0001 << k) : 4'b0000;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("unit_en", 64'(unit_en), 64'(k >= 0));
        if (k >= 0) begin
            chk("unit_tag", 64'(unit_tag), 64'(k));
            chk("unit_opa", 64'(unit_opa), 64'(opa[k]));
            chk("unit_opb", 64'(unit_opb), 64'(opb[k]));
            chk("unit_rnd", 64'(unit_rnd), 64'(rnd[k]));
        end else begin
            chk("idle_opa", 64'(unit_opa), 64'(0));
            chk("idle_opb", 64'(unit_opb), 64'(0));
        end
        chk("unit_ack", 64'(unit_ack), 64'(unit_valid));
        if (known) begin
            chk("rvalid", 64'(rvalid), 64'(m_rv));
            chk("res", 64'(res), 64'(m_res));
            chk("status", 64'(status), 64'(m_st));
            chk("err", 64'(err), 64'(m_err));
        end
        obs_gnt  = gnt;
        obs_en   = unit_en;
        obs_tag  = unit_tag;
        obs_rv   = rvalid;
        obs_res  = res;
        obs_err  = err;
        last_gnt = eg;
        ret   = unit_valid;
        rtag  = unit_tag_in;
        rres  = unit_res;
        rstat = unit_status;
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_infl = 0; m_rv = '0; m_res = '0; m_st = '0; m_err = 1'b0;
            known = 1;
        end else begin
            if (ret) begin
                if (m_infl == 0) m_err = 1'b1;
                else m_infl--;
                m_rv  = 4'b0001 << rtag;
                m_res = rres;
                m_st  = rstat;
            end else begin
                m_rv = '0;
            end
            if (k >= 0) begin
                m_infl++;
                m_ptr = (k + 1) % NC;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '1;
        ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        req   = '0;
    endtask

    initial begin
        rst_n = 1'b0; ready = 1'b1; req = '1;
        inj_valid = 1'b0; inj_tag = '0; inj_res = '0; inj_stat = '0;
        for (int k = 0; k < NC; k++) begin
            opa[k] = $urandom(); opb[k] = $urandom(); rnd[k] = RW'($urandom_range(0, 7));
        end

        // reset with every core requesting
        step();
        step();
        chk("rst_gnt", 64'(obs_gnt), 64'(0));
        chk("rst_en", 64'(obs_en), 64'(0));
        chk("rst_rvalid", 64'(obs_rv), 64'(0));
        chk("rst_err", 64'(obs_err), 64'(0));
        rst_n = 1'b1;
        req   = '0;

        // single op from core 2, latency 2
        req = 4'b0100; opa[2] = 32'h4000_0000; opb[2] = 32'h4040_0000; rnd[2] = 3'd1;
        step();
        chk("single_gnt", 64'(obs_gnt), 64'(4'b0100));
        chk("single_tag", 64'(obs_tag), 64'(2));
        req = '0;
        step();
        step();
        chk("single_early", 64'(obs_rv), 64'(0));
        step();
        chk("single_rvalid", 64'(obs_rv), 64'(4'b0100));
        chk("single_res", 64'(obs_res), 64'(32'h40C0_0000));

        // fairness at full throughput
        lat = 1;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            hist[i] = obs_gnt;
        end
        for (int i = 0; i < 8; i++) chk("fair_order", 64'(hist[i]), 64'(4'b0001 << (i % 4)));
        req = '0;
        repeat (3) step();

        // credits exhausted with latency 4
        lat = 4;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            step();
            hist[i] = obs_gnt;
        end
        chk("cred_g0", 64'(hist[0]), 64'(4'b0001));
        chk("cred_g1", 64'(hist[1]), 64'(4'b0010));
        for (int i = 2; i < 5; i++) chk("cred_block", 64'(hist[i]), 64'(0));
        chk("cred_resume", 64'(hist[5]), 64'(4'b0100));
        req = '0;
        repeat (8) step();

        // stall holds the pointer
        lat = 2;
        do_reset();
        req = 4'b0001;
        step();
        chk("stall_pre", 64'(obs_gnt), 64'(4'b0001));
        req = 4'b0011; ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_gnt", 64'(obs_gnt), 64'(0));
        end
        ready = 1'b1;
        step();
        chk("stall_release", 64'(obs_gnt), 64'(4'b0010));
        req = '0;
        repeat (5) step();

        // return with no credit outstanding
        do_reset();
        step();
        inj_valid = 1'b1; inj_tag = 2'd1; inj_res = 32'h1234_5678; inj_stat = 8'h5A;
        step();
        inj_valid = 1'b0;
        step();
        chk("err_set", 64'(obs_err), 64'(1));
        chk("err_rvalid", 64'(obs_rv), 64'(4'b0010));
        chk("err_res", 64'(obs_res), 64'(32'h1234_5678));
        repeat (3) step();
        chk("err_sticky", 64'(obs_err), 64'(1));
        do_reset();
        chk("err_cleared", 64'(obs_err), 64'(0));

        // randomized traffic, credit-limited at latency 3
        lat = 3;
        do_reset();
        last_gnt = '0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NC; k++) begin
                if (!(req[k] && !last_gnt[k])) begin
                    req[k] = ($urandom_range(0, 99) < 55);
                    if (req[k]) begin
                        opa[k] = $urandom();
                        opb[k] = $urandom();
                        rnd[k] = RW'($urandom_range(0, 7));
                    end
                end
            end
            ready = ($urandom_range(0, 9) != 0);
            step();
        end
        req = '0; ready = 1'b1;
        repeat (10) step();
        chk("final_err", 64'(obs_err), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
